// File: rtl/tlb_pkg.sv
// Shared TLB types: entry layout, field widths and invalidation sweep states.
package tlb_pkg;
   localparam int VPN2_W = 19;
   localparam int PFN_W  = 20;
   localparam int ASID_W = 8;
   localparam int C_W    = 3;

   typedef struct packed {
      logic [VPN2_W-1:0] vpn2;
      logic [ASID_W-1:0] asid;
      logic              g;
      logic [PFN_W-1:0]  pfn0;
      logic [C_W-1:0]    c0;
      logic              d0;
      logic              v0;
      logic [PFN_W-1:0]  pfn1;
      logic [C_W-1:0]    c1;
      logic              d1;
      logic              v1;
   } tlb_entry_t;

   localparam int ENTRY_W = $bits(tlb_entry_t);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} inv_state_e;
endpackage

// File: rtl/tlb_match_port.sv
// One combinational search port: match vector, lowest-index priority pick,
// multi-hit flag and even/odd page field select.
module tlb_match_port
   import tlb_pkg::*;
#(
   parameter int TLBNUM = 16,
   parameter int IW     = $clog2(TLBNUM)
) (
   input  logic [TLBNUM*ENTRY_W-1:0] entries,
   input  logic [VPN2_W-1:0]         vpn2,
   input  logic [ASID_W-1:0]         asid,
   input  logic                      odd_page,
   output logic                      found,
   output logic                      multi,
   output logic [IW-1:0]             index,
   output logic [PFN_W-1:0]          pfn,
   output logic [C_W-1:0]            c,
   output logic                      d,
   output logic                      v
);
   tlb_entry_t        ent [TLBNUM];
   tlb_entry_t        sel;
   logic [TLBNUM-1:0] match;

   for (genvar i = 0; i < TLBNUM; i++) begin : g_ent
      assign ent[i]   = tlb_entry_t'(entries[i*ENTRY_W +: ENTRY_W]);
      assign match[i] = (ent[i].vpn2 == vpn2) && ((ent[i].asid == asid) || ent[i].g);
   end

   always_comb begin
      index = '0;
      for (int i = TLBNUM-1; i >= 0; i--)
         if (match[i]) index = IW'(i);
   end

   // Clearing the lowest set bit leaves something only when two or more hit.
   assign found = |match;
   assign multi = |(match & (match - TLBNUM'(1)));
   assign sel   = ent[index];

   always_comb begin
      pfn = '0;
      c   = '0;
      d   = 1'b0;
      v   = 1'b0;
      if (found) begin
         pfn = odd_page ? sel.pfn1 : sel.pfn0;
         c   = odd_page ? sel.c1   : sel.c0;
         d   = odd_page ? sel.d1   : sel.d0;
         v   = odd_page ? sel.v1   : sel.v0;
      end
   end
endmodule

// File: rtl/tlb_mgr.sv
// Parametrised TLB: NPORT registered search ports, registered read port,
// write port, ASID/all invalidation sweep and Random index generator.
module tlb_mgr
   import tlb_pkg::*;
#(
   parameter  int TLBNUM = 16,
   parameter  int NPORT  = 2,
   localparam int IW     = $clog2(TLBNUM)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NPORT-1:0]        s_req,
   input  logic [NPORT*VPN2_W-1:0] s_vpn2,
   input  logic [NPORT-1:0]        s_odd_page,
   input  logic [NPORT*ASID_W-1:0] s_asid,
   output logic [NPORT-1:0]        s_rvalid,
   output logic [NPORT-1:0]        s_found,
   output logic [NPORT-1:0]        s_multi,
   output logic [NPORT*IW-1:0]     s_index,
   output logic [NPORT*PFN_W-1:0]  s_pfn,
   output logic [NPORT*C_W-1:0]    s_c,
   output logic [NPORT-1:0]        s_d,
   output logic [NPORT-1:0]        s_v,
   input  logic                    we,
   input  logic [IW-1:0]           w_index,
   input  logic [VPN2_W-1:0]       w_vpn2,
   input  logic [ASID_W-1:0]       w_asid,
   input  logic                    w_g,
   input  logic [PFN_W-1:0]        w_pfn0,
   input  logic [C_W-1:0]          w_c0,
   input  logic                    w_d0,
   input  logic                    w_v0,
   input  logic [PFN_W-1:0]        w_pfn1,
   input  logic [C_W-1:0]          w_c1,
   input  logic                    w_d1,
   input  logic                    w_v1,
   input  logic [IW-1:0]           r_index,
   output logic [VPN2_W-1:0]       r_vpn2,
   output logic [ASID_W-1:0]       r_asid,
   output logic                    r_g,
   output logic [PFN_W-1:0]        r_pfn0,
   output logic [C_W-1:0]          r_c0,
   output logic                    r_d0,
   output logic                    r_v0,
   output logic [PFN_W-1:0]        r_pfn1,
   output logic [C_W-1:0]          r_c1,
   output logic                    r_d1,
   output logic                    r_v1,
   input  logic                    inv_req,
   input  logic                    inv_mode,
   input  logic [ASID_W-1:0]       inv_asid,
   output logic                    inv_busy,
   output logic                    inv_done,
   input  logic [IW-1:0]           wired,
   input  logic                    wired_we,
   output logic [IW-1:0]           rand_index
);
   localparam logic [IW-1:0] LAST = IW'(TLBNUM-1);

   tlb_entry_t                 tlb [TLBNUM];
   logic [TLBNUM*ENTRY_W-1:0]  tlb_flat;
   tlb_entry_t                 w_entry, r_q;
   inv_state_e                 state;
   logic [IW-1:0]              ptr;
   logic                       mode_q;
   logic [ASID_W-1:0]          asid_q;

   logic [NPORT-1:0][IW-1:0]    m_index, index_q;
   logic [NPORT-1:0][PFN_W-1:0] m_pfn, pfn_q;
   logic [NPORT-1:0][C_W-1:0]   m_c, c_q;
   logic [NPORT-1:0]            m_found, m_multi, m_d, m_v;

   assign w_entry = {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1};

   for (genvar i = 0; i < TLBNUM; i++) begin : g_flat
      assign tlb_flat[i*ENTRY_W +: ENTRY_W] = tlb[i];
   end

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      tlb_match_port #(.TLBNUM(TLBNUM), .IW(IW)) u_port (
         .entries  (tlb_flat),
         .vpn2     (s_vpn2[p*VPN2_W +: VPN2_W]),
         .asid     (s_asid[p*ASID_W +: ASID_W]),
         .odd_page (s_odd_page[p]),
         .found    (m_found[p]),
         .multi    (m_multi[p]),
         .index    (m_index[p]),
         .pfn      (m_pfn[p]),
         .c        (m_c[p]),
         .d        (m_d[p]),
         .v        (m_v[p])
      );
   end

   // Result fields only update on a request so they hold between lookups.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_rvalid <= '0;
         s_found  <= '0;
         s_multi  <= '0;
         s_d      <= '0;
         s_v      <= '0;
         index_q  <= '0;
         pfn_q    <= '0;
         c_q      <= '0;
      end else begin
         s_rvalid <= s_req;
         for (int p = 0; p < NPORT; p++) begin
            if (s_req[p]) begin
               s_found[p] <= m_found[p];
               s_multi[p] <= m_multi[p];
               s_d[p]     <= m_d[p];
               s_v[p]     <= m_v[p];
               index_q[p] <= m_index[p];
               pfn_q[p]   <= m_pfn[p];
               c_q[p]     <= m_c[p];
            end
         end
      end
   end

   assign s_index = index_q;
   assign s_pfn   = pfn_q;
   assign s_c     = c_q;

   // Table: the sweep owns the table while busy, so writes then are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TLBNUM; i++) tlb[i] <= '0;
      end else if (state == SWEEP) begin
         if (!mode_q || (!tlb[ptr].g && tlb[ptr].asid == asid_q)) begin
            tlb[ptr].v0 <= 1'b0;
            tlb[ptr].v1 <= 1'b0;
         end
      end else if (we) begin
         tlb[w_index] <= w_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_q <= '0;
      else       r_q <= tlb[r_index];
   end

   assign {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} = r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         mode_q   <= 1'b0;
         asid_q   <= '0;
         inv_busy <= 1'b0;
         inv_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               inv_done <= 1'b0;
               if (inv_req) begin
                  state    <= SWEEP;
                  ptr      <= '0;
                  mode_q   <= inv_mode;
                  asid_q   <= inv_asid;
                  inv_busy <= 1'b1;
               end
            end
            SWEEP: begin
               ptr <= ptr + 1'b1;
               if (ptr == LAST) begin
                  state    <= DONE;
                  inv_busy <= 1'b0;
                  inv_done <= 1'b1;
               end
            end
            DONE: begin
               inv_done <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Random stays in [wired, TLBNUM-1]; a Wired write restarts it at the top.
   always_ff @(posedge clk) begin
      if (reset)                              rand_index <= LAST;
      else if (wired_we || rand_index <= wired) rand_index <= LAST;
      else                                    rand_index <= rand_index - 1'b1;
   end
endmodule

// File: tb/tb_tlb_mgr.sv
// Bench for tlb_mgr: lookups checked through a reference-model scoreboard,
// sweep, read port and Random counter checked inline per scenario.
module tb_tlb_mgr;
   import tlb_pkg::*;

   localparam int TN = 16;
   localparam int NP = 2;
   localparam int IW = 4;

   typedef struct packed {
      logic            found;
      logic            multi;
      logic [IW-1:0]   index;
      logic [19:0]     pfn;
      logic [2:0]      c;
      logic            d;
      logic            v;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic [NP-1:0] s_req, s_odd_page, s_rvalid, s_found, s_multi, s_d, s_v;
   logic [NP*19-1:0] s_vpn2;
   logic [NP*8-1:0]  s_asid;
   logic [NP*IW-1:0] s_index;
   logic [NP*20-1:0] s_pfn;
   logic [NP*3-1:0]  s_c;
   logic we, w_g, w_d0, w_v0, w_d1, w_v1;
   logic [IW-1:0] w_index, r_index, wired, rand_index;
   logic [18:0] w_vpn2, r_vpn2;
   logic [7:0]  w_asid, r_asid, inv_asid;
   logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
   logic [2:0]  w_c0, w_c1, r_c0, r_c1;
   logic r_g, r_d0, r_v0, r_d1, r_v1;
   logic inv_req, inv_mode, inv_busy, inv_done, wired_we;

   int tests = 0;
   int fails = 0;
   tlb_entry_t mdl [TN];
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   tlb_mgr #(.TLBNUM(TN), .NPORT(NP)) dut (
      .clk(clk), .reset(reset),
      .s_req(s_req), .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
      .s_rvalid(s_rvalid), .s_found(s_found), .s_multi(s_multi), .s_index(s_index),
      .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v),
      .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
      .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
      .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
      .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
      .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
      .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
      .inv_req(inv_req), .inv_mode(inv_mode), .inv_asid(inv_asid),
      .inv_busy(inv_busy), .inv_done(inv_done),
      .wired(wired), .wired_we(wired_we), .rand_index(rand_index)
   );

   function automatic tlb_entry_t mk(logic [18:0] vpn2, logic [7:0] asid, logic g,
                                     logic [19:0] pfn0, logic v0, logic [19:0] pfn1, logic v1);
      tlb_entry_t e;
      e.vpn2 = vpn2; e.asid = asid; e.g = g;
      e.pfn0 = pfn0; e.c0 = 3'd3; e.d0 = v0; e.v0 = v0;
      e.pfn1 = pfn1; e.c1 = 3'd5; e.d1 = 1'b1; e.v1 = v1;
      return e;
   endfunction

   function automatic exp_t model_lookup(logic [18:0] vpn2, logic [7:0] asid, logic odd);
      exp_t r = '0;
      int n = 0;
      for (int i = 0; i < TN; i++) begin
         if (mdl[i].vpn2 == vpn2 && (mdl[i].asid == asid || mdl[i].g)) begin
            if (n == 0) begin
               r.found = 1'b1;
               r.index = IW'(i);
               r.pfn = odd ? mdl[i].pfn1 : mdl[i].pfn0;
               r.c   = odd ? mdl[i].c1   : mdl[i].c0;
               r.d   = odd ? mdl[i].d1   : mdl[i].d0;
               r.v   = odd ? mdl[i].v1   : mdl[i].v0;
            end
            n++;
         end
      end
      r.multi = (n > 1);
      return r;
   endfunction

   // Pulse inputs last exactly one edge.
   task automatic tick();
      @(posedge clk); #1;
      s_req = '0; we = 1'b0; inv_req = 1'b0; wired_we = 1'b0;
   endtask

   // Expectation taken from the model as it stands before any write driven in this phase.
   task automatic lookup(int p, logic [18:0] vpn2, logic [7:0] asid, logic odd);
      s_req[p] = 1'b1;
      s_vpn2[p*19 +: 19] = vpn2;
      s_asid[p*8 +: 8] = asid;
      s_odd_page[p] = odd;
      if (p == 0) q0.push_back(model_lookup(vpn2, asid, odd));
      else        q1.push_back(model_lookup(vpn2, asid, odd));
   endtask

   task automatic drive_w(int idx, tlb_entry_t e);
      we = 1'b1; w_index = IW'(idx);
      {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1} = e;
   endtask

   task automatic wr(int idx, tlb_entry_t e);
      drive_w(idx, e);
      mdl[idx] = e;
   endtask

   task automatic clear_model();
      for (int i = 0; i < TN; i++) mdl[i] = '0;
   endtask

   always @(negedge clk) begin
      exp_t got, e;
      for (int p = 0; p < NP; p++) begin
         if (s_rvalid[p]) begin
            got = {s_found[p], s_multi[p], s_index[p*IW +: IW], s_pfn[p*20 +: 20],
                   s_c[p*3 +: 3], s_d[p], s_v[p]};
            tests++;
            if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
               fails++;
               $display("FAIL unexpected_rvalid_p%0d got=%h exp=none", p, got);
            end else begin
               if (p == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               if (got !== e) begin
                  fails++;
                  $display("FAIL lookup_p%0d got=%h exp=%h", p, got, e);
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      tests++;
      if ({s_rvalid, s_found, s_multi, s_index, s_pfn, s_c, s_d, s_v} !== '0) begin
         fails++; $display("FAIL reset_search got=%h exp=0", {s_rvalid, s_found, s_index, s_pfn});
      end
      tests++;
      if ({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} !== '0) begin
         fails++; $display("FAIL reset_read got=%h exp=0", {r_vpn2, r_asid, r_pfn0, r_pfn1});
      end
      tests++;
      if ({inv_busy, inv_done} !== 2'b00) begin
         fails++; $display("FAIL reset_inv got=%b%b exp=00", inv_busy, inv_done);
      end
      tests++;
      if (rand_index !== 4'd15) begin
         fails++; $display("FAIL reset_rand got=%0d exp=15", rand_index);
      end
      reset = 1'b0;
      clear_model();
   endtask

   task automatic test_basic_hit();
      wr(3, mk(19'h00012, 8'h05, 1'b0, 20'h00ABC, 1'b1, 20'h0, 1'b0));
      tick();
      lookup(0, 19'h00012, 8'h05, 1'b0); tick();
      lookup(0, 19'h00012, 8'h06, 1'b0); tick();
      lookup(0, 19'h00012, 8'h05, 1'b1);
      r_index = 4'd3;
      tick();
      tests++;
      if ({r_vpn2, r_asid, r_g, r_pfn0, r_v0} !== {19'h00012, 8'h05, 1'b0, 20'h00ABC, 1'b1}) begin
         fails++; $display("FAIL read_idx3 got=%h/%h/%h exp=12/05/ABC", r_vpn2, r_asid, r_pfn0);
      end
      tick();
   endtask

   task automatic test_multi_hit();
      wr(2, mk(19'h00345, 8'h11, 1'b1, 20'h22222, 1'b1, 20'h22223, 1'b1)); tick();
      wr(9, mk(19'h00345, 8'h33, 1'b1, 20'h99999, 1'b1, 20'h9999A, 1'b0)); tick();
      lookup(0, 19'h00345, 8'hAA, 1'b0);
      lookup(1, 19'h00345, 8'h00, 1'b1);
      tick();
      lookup(0, 19'h00777, 8'h05, 1'b0);
      lookup(1, 19'h00012, 8'h05, 1'b0);
      tick(); tick();
   endtask

   task automatic test_back_to_back();
      lookup(0, 19'h00055, 8'h01, 1'b0);
      wr(5, mk(19'h00055, 8'h01, 1'b0, 20'h55555, 1'b1, 20'h55556, 1'b1));
      tick();
      lookup(0, 19'h00055, 8'h01, 1'b1);
      tick();
      tick();
      tests++;
      if ({s_rvalid[0], s_found[0], s_index[IW-1:0]} !== {1'b0, 1'b1, 4'd5}) begin
         fails++; $display("FAIL hold_result got=%b/%b/%0d exp=0/1/5", s_rvalid[0], s_found[0], s_index[IW-1:0]);
      end
   endtask

   task automatic test_inv_sweep();
      int busy_cnt = 0, done_cnt = 0, busy_at_done = -1;
      wr(0, mk(19'h00100, 8'h07, 1'b0, 20'h10000, 1'b1, 20'h10001, 1'b1)); tick();
      wr(1, mk(19'h00101, 8'h07, 1'b0, 20'h10100, 1'b1, 20'h10101, 1'b1)); tick();
      wr(4, mk(19'h00104, 8'h07, 1'b1, 20'h10400, 1'b1, 20'h10401, 1'b1)); tick();
      inv_req = 1'b1; inv_mode = 1'b1; inv_asid = 8'h07;
      tick();
      for (int cyc = 0; cyc < 24; cyc++) begin
         if (inv_busy) busy_cnt++;
         if (inv_done) begin done_cnt++; busy_at_done = busy_cnt; end
         if (cyc == 3) begin
            drive_w(4, mk(19'h00104, 8'h07, 1'b1, 20'hDEAD0, 1'b0, 20'hDEAD1, 1'b0));
            inv_req = 1'b1; inv_mode = 1'b0;
         end
         tick();
      end
      tests++;
      if (busy_cnt != 16) begin
         fails++; $display("FAIL inv_busy_len got=%0d exp=16", busy_cnt);
      end
      tests++;
      if (done_cnt != 1 || busy_at_done != 16) begin
         fails++; $display("FAIL inv_done_pulse got=%0d@%0d exp=1@16", done_cnt, busy_at_done);
      end
      for (int i = 0; i < TN; i++)
         if (!mdl[i].g && mdl[i].asid == 8'h07) begin mdl[i].v0 = 1'b0; mdl[i].v1 = 1'b0; end
      lookup(0, 19'h00100, 8'h07, 1'b0);
      lookup(1, 19'h00104, 8'h07, 1'b1);
      r_index = 4'd0;
      tick();
      tests++;
      if ({r_v0, r_v1} !== 2'b00) begin
         fails++; $display("FAIL inv_entry0_valid got=%b%b exp=00", r_v0, r_v1);
      end
      lookup(0, 19'h00101, 8'h07, 1'b1);
      lookup(1, 19'h00012, 8'h05, 1'b0);
      r_index = 4'd4;
      tick();
      tests++;
      if ({r_pfn0, r_v0, r_v1} !== {20'h10400, 1'b1, 1'b1}) begin
         fails++; $display("FAIL inv_entry4_kept got=%h/%b%b exp=10400/11", r_pfn0, r_v0, r_v1);
      end
      tick();
   endtask

   task automatic test_random();
      logic [IW-1:0] exp_r;
      wired = '0;
      reset = 1'b1; tick(); reset = 1'b0;
      clear_model();
      for (int i = 0; i < 17; i++) begin
         exp_r = (i == 16) ? 4'd15 : IW'(15 - i);
         tests++;
         if (rand_index !== exp_r) begin
            fails++; $display("FAIL rand_w0_%0d got=%0d exp=%0d", i, rand_index, exp_r);
         end
         tick();
      end
      wired = 4'd12; wired_we = 1'b1;
      tick();
      for (int j = 0; j < 5; j++) begin
         exp_r = (j < 4) ? IW'(15 - j) : 4'd15;
         tests++;
         if (rand_index !== exp_r) begin
            fails++; $display("FAIL rand_w12_%0d got=%0d exp=%0d", j, rand_index, exp_r);
         end
         tick();
      end
      wired = 4'd15; wired_we = 1'b1;
      tick();
      for (int j = 0; j < 4; j++) begin
         tests++;
         if (rand_index !== 4'd15) begin
            fails++; $display("FAIL rand_w15_%0d got=%0d exp=15", j, rand_index);
         end
         tick();
      end
      wired = '0;
   endtask

   task automatic test_reset_mid_sweep();
      int stray = 0;
      wr(6, mk(19'h00066, 8'h01, 1'b1, 20'h66660, 1'b1, 20'h66661, 1'b1)); tick();
      wr(3, mk(19'h00012, 8'h05, 1'b0, 20'h00ABC, 1'b1, 20'h0, 1'b0)); tick();
      inv_req = 1'b1; inv_mode = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      tests++;
      if ({inv_busy, inv_done} !== 2'b00) begin
         fails++; $display("FAIL abort_sweep got=%b%b exp=00", inv_busy, inv_done);
      end
      reset = 1'b0;
      clear_model();
      lookup(0, 19'h00066, 8'h01, 1'b0);
      lookup(1, 19'h00012, 8'h05, 1'b0);
      tick();
      for (int i = 0; i < 20; i++) begin
         if (inv_busy || inv_done) stray++;
         tick();
      end
      tests++;
      if (stray != 0) begin
         fails++; $display("FAIL abort_no_done got=%0d exp=0", stray);
      end
   endtask

   initial begin
      reset = 1'b1;
      s_req = '0; s_vpn2 = '0; s_odd_page = '0; s_asid = '0;
      we = 1'b0; w_index = '0;
      {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1} = '0;
      r_index = '0; inv_req = 1'b0; inv_mode = 1'b0; inv_asid = '0;
      wired = '0; wired_we = 1'b0;
      clear_model();

      test_reset();
      test_basic_hit();
      test_multi_hit();
      test_back_to_back();
      test_inv_sweep();
      test_random();
      test_reset_mid_sweep();

      tick(); tick(); tick();
      tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
         fails++; $display("FAIL pending_results got=%0d/%0d exp=0/0", q0.size(), q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
